// File: rtl/trigger_seq.sv
// trigger_seq: capture trigger sequencer.
//
// Combines per-channel trigger flags and an optional protocol trigger into
// a single match term (AND or OR of the participating terms). A match must
// persist for qual_len extra cycles to count as one qualified event. Once
// max(event_cnt,1) events have been seen while armed, the block enters TRIG
// and holds there until the capture engine reports completion.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   ch_trig          per-channel trigger-condition-met flags
//   ch_mask          per-channel enable (1 = channel participates)
//   prot_trig        protocol trigger-met flag
//   prot_en          1 = prot_trig participates as one more term
//   mode             0 = AND of participating terms, 1 = OR
//   qual_len         extra consecutive match cycles required per event
//   event_cnt        number of events to trigger on (0 behaves as 1)
//   armed            capture armed
//   set_capture_done capture finished, releases the trigger
//   triggered        registered, high while in TRIG
//   trig_pulse       registered, one-cycle pulse on TRIG entry
//   waiting          registered, high while in ARM
//   events_seen      qualified events counted in the current arm
module trigger_seq #(
    parameter int NUM_CH = 5,
    parameter int QUAL_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              prot_trig,
    input  logic              prot_en,
    input  logic              mode,
    input  logic [QUAL_W-1:0] qual_len,
    input  logic [CNT_W-1:0]  event_cnt,
    input  logic              armed,
    input  logic              set_capture_done,
    output logic              triggered,
    output logic              trig_pulse,
    output logic              waiting,
    output logic [CNT_W-1:0]  events_seen
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        TRIG = 2'd2
    } state_t;

    localparam logic [QUAL_W-1:0] RUN_ONE = {{(QUAL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r, state_nx_s;

    // Configuration captured on arming; evaluation never looks at live config.
    logic [NUM_CH-1:0]   mask_r, mask_nx_s;
    logic                prot_en_r, prot_en_nx_s;
    logic                mode_r, mode_nx_s;
    logic [QUAL_W-1:0]   qual_len_r, qual_len_nx_s;
    logic [CNT_W-1:0]    event_cnt_r, event_cnt_nx_s;

    logic [QUAL_W-1:0]   run_r, run_nx_s;
    // Set once the current match assertion has produced its event.
    logic                fired_r, fired_nx_s;
    logic [CNT_W-1:0]    events_seen_r, events_seen_nx_s;

    logic                triggered_r, triggered_nx_s;
    logic                trig_pulse_r, trig_pulse_nx_s;
    logic                waiting_r, waiting_nx_s;

    logic                any_term_s;
    logic                and_term_s;
    logic                or_term_s;
    logic                match_s;
    logic                event_s;
    logic                final_s;
    logic [CNT_W-1:0]    target_s;

    // Combine participating terms; unmasked channels read as "true" for AND
    // and as "false" for OR so they drop out of either reduction.
    always_comb begin
        any_term_s = (|mask_r) | prot_en_r;
        and_term_s = (&(ch_trig | ~mask_r)) & (prot_trig | ~prot_en_r);
        or_term_s  = (|(ch_trig & mask_r)) | (prot_trig & prot_en_r);
        if ((state_r == ARM) && any_term_s) begin
            match_s = mode_r ? or_term_s : and_term_s;
        end else begin
            match_s = 1'b0;
        end
    end

    // Event detection and trigger target (event_cnt of zero means one event).
    always_comb begin
        if (event_cnt_r == {CNT_W{1'b0}}) begin
            target_s = CNT_ONE;
        end else begin
            target_s = event_cnt_r;
        end
        event_s = match_s && (run_r == qual_len_r) && !fired_r;
        final_s = event_s && (events_seen_r == (target_s - CNT_ONE));
    end

    // Next-state and next-register logic for the sequencer.
    always_comb begin
        state_nx_s       = state_r;
        mask_nx_s        = mask_r;
        prot_en_nx_s     = prot_en_r;
        mode_nx_s        = mode_r;
        qual_len_nx_s    = qual_len_r;
        event_cnt_nx_s   = event_cnt_r;
        run_nx_s         = run_r;
        fired_nx_s       = fired_r;
        events_seen_nx_s = events_seen_r;

        case (state_r)
            IDLE: begin
                if (armed) begin
                    state_nx_s       = ARM;
                    mask_nx_s        = ch_mask;
                    prot_en_nx_s     = prot_en;
                    mode_nx_s        = mode;
                    qual_len_nx_s    = qual_len;
                    event_cnt_nx_s   = event_cnt;
                    run_nx_s         = {QUAL_W{1'b0}};
                    fired_nx_s       = 1'b0;
                    events_seen_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ARM: begin
                if (!armed) begin
                    // Disarm wins over a coincident final event.
                    state_nx_s       = IDLE;
                    run_nx_s         = {QUAL_W{1'b0}};
                    fired_nx_s       = 1'b0;
                    events_seen_nx_s = {CNT_W{1'b0}};
                end else begin
                    if (match_s) begin
                        if (run_r != qual_len_r) begin
                            run_nx_s = run_r + RUN_ONE;
                        end else begin
                            run_nx_s = run_r;
                        end
                        fired_nx_s = fired_r | event_s;
                    end else begin
                        run_nx_s   = {QUAL_W{1'b0}};
                        fired_nx_s = 1'b0;
                    end
                    if (event_s) begin
                        events_seen_nx_s = events_seen_r + CNT_ONE;
                    end else begin
                        events_seen_nx_s = events_seen_r;
                    end
                    if (final_s) begin
                        state_nx_s = TRIG;
                    end else begin
                        state_nx_s = ARM;
                    end
                end
            end
            TRIG: begin
                if (set_capture_done) begin
                    state_nx_s       = IDLE;
                    run_nx_s         = {QUAL_W{1'b0}};
                    fired_nx_s       = 1'b0;
                    events_seen_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = TRIG;
                end
            end
            default: begin
                state_nx_s       = IDLE;
                run_nx_s         = {QUAL_W{1'b0}};
                fired_nx_s       = 1'b0;
                events_seen_nx_s = {CNT_W{1'b0}};
            end
        endcase

        triggered_nx_s  = (state_nx_s == TRIG);
        waiting_nx_s    = (state_nx_s == ARM);
        trig_pulse_nx_s = (state_nx_s == TRIG) && (state_r != TRIG);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Shadow config, qualification counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r        <= {NUM_CH{1'b0}};
            prot_en_r     <= 1'b0;
            mode_r        <= 1'b0;
            qual_len_r    <= {QUAL_W{1'b0}};
            event_cnt_r   <= {CNT_W{1'b0}};
            run_r         <= {QUAL_W{1'b0}};
            fired_r       <= 1'b0;
            events_seen_r <= {CNT_W{1'b0}};
            triggered_r   <= 1'b0;
            trig_pulse_r  <= 1'b0;
            waiting_r     <= 1'b0;
        end else begin
            mask_r        <= mask_nx_s;
            prot_en_r     <= prot_en_nx_s;
            mode_r        <= mode_nx_s;
            qual_len_r    <= qual_len_nx_s;
            event_cnt_r   <= event_cnt_nx_s;
            run_r         <= run_nx_s;
            fired_r       <= fired_nx_s;
            events_seen_r <= events_seen_nx_s;
            triggered_r   <= triggered_nx_s;
            trig_pulse_r  <= trig_pulse_nx_s;
            waiting_r     <= waiting_nx_s;
        end
    end

    assign triggered   = triggered_r;
    assign trig_pulse  = trig_pulse_r;
    assign waiting     = waiting_r;
    assign events_seen = events_seen_r;

endmodule

// File: tb/tb_trigger_seq.sv
// Testbench for trigger_seq: table of per-cycle vectors with expected
// outputs after each clock edge, checked through an expectation queue,
// plus loops for the long zero-term scenario.
module tb_trigger_seq;

    localparam int NUM_CH = 5;
    localparam int QUAL_W = 8;
    localparam int CNT_W  = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_trig;
    logic [NUM_CH-1:0] ch_mask;
    logic              prot_trig;
    logic              prot_en;
    logic              mode;
    logic [QUAL_W-1:0] qual_len;
    logic [CNT_W-1:0]  event_cnt;
    logic              armed;
    logic              set_capture_done;
    logic              triggered;
    logic              trig_pulse;
    logic              waiting;
    logic [CNT_W-1:0]  events_seen;

    always #5 clk = ~clk;

    trigger_seq #(
        .NUM_CH(NUM_CH),
        .QUAL_W(QUAL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ch_trig         (ch_trig),
        .ch_mask         (ch_mask),
        .prot_trig       (prot_trig),
        .prot_en         (prot_en),
        .mode            (mode),
        .qual_len        (qual_len),
        .event_cnt       (event_cnt),
        .armed           (armed),
        .set_capture_done(set_capture_done),
        .triggered       (triggered),
        .trig_pulse      (trig_pulse),
        .waiting         (waiting),
        .events_seen     (events_seen)
    );

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic              pen;
        logic              md;
        logic [QUAL_W-1:0] qual;
        logic [CNT_W-1:0]  ecnt;
    } cfg_t;

    typedef struct {
        string             tag;
        logic              r;
        logic              a;
        logic              d;
        logic [NUM_CH-1:0] ch;
        logic              p;
        int                cfg;
        logic              t;
        logic              pl;
        logic              w;
        logic [CNT_W-1:0]  e;
    } vec_t;

    cfg_t              cfgs[7];
    vec_t              vecs[$];
    logic [10:0]       exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    function automatic void v(input string tag, input logic r, input logic a, input logic d,
                              input logic [NUM_CH-1:0] ch, input logic p, input int cfg,
                              input logic t, input logic pl, input logic w,
                              input logic [CNT_W-1:0] e);
        vecs.push_back('{tag, r, a, d, ch, p, cfg, t, pl, w, e});
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then pop and compare after the edge.
    task automatic drive_cycle(input vec_t x, input string name);
        logic [10:0] exp_v;
        logic [10:0] act_v;
        rst              = x.r;
        armed            = x.a;
        set_capture_done = x.d;
        ch_trig          = x.ch;
        prot_trig        = x.p;
        ch_mask          = cfgs[x.cfg].mask;
        prot_en          = cfgs[x.cfg].pen;
        mode             = cfgs[x.cfg].md;
        qual_len         = cfgs[x.cfg].qual;
        event_cnt        = cfgs[x.cfg].ecnt;
        exp_q.push_back({x.t, x.pl, x.w, x.e});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        act_v = {triggered, trig_pulse, waiting, events_seen};
        n_checks++;
        if (act_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got trig/pulse/wait/ev=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     name, act_v[10], act_v[9], act_v[8], act_v[7:0],
                     exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
        end
    endtask

    initial begin
        vec_t x;
        rst = 1'b1; armed = 1'b0; set_capture_done = 1'b0; ch_trig = 5'h00;
        prot_trig = 1'b0; ch_mask = 5'h00; prot_en = 1'b0; mode = 1'b0;
        qual_len = 8'd0; event_cnt = 8'd0;

        //              mask   pen md qual   ecnt
        cfgs[0] = '{5'h1F, H, L, 8'd0, 8'd1};
        cfgs[1] = '{5'h04, L, H, 8'd3, 8'd1};
        cfgs[2] = '{5'h01, L, H, 8'd0, 8'd3};
        cfgs[3] = '{5'h00, L, L, 8'd0, 8'd1};
        cfgs[4] = '{5'h00, L, H, 8'd0, 8'd1};
        cfgs[5] = '{5'h01, L, H, 8'd0, 8'd0};
        cfgs[6] = '{5'h00, H, L, 8'd0, 8'd1};

        // reset and idle behaviour
        v("rst",   H, L, L, 5'h00, L, 0,  L, L, L, 8'd0);
        v("idle",  L, L, L, 5'h00, L, 0,  L, L, L, 8'd0);
        v("idle",  L, L, H, 5'h1F, H, 0,  L, L, L, 8'd0);
        // AND of all five channels and protocol trigger
        v("and",   L, H, L, 5'h00, L, 0,  L, L, H, 8'd0);
        v("and",   L, H, L, 5'h1F, L, 0,  L, L, H, 8'd0);
        v("and",   L, H, L, 5'h0F, H, 0,  L, L, H, 8'd0);
        v("and",   L, H, H, 5'h00, L, 0,  L, L, H, 8'd0);
        v("and",   L, H, L, 5'h1F, H, 0,  H, H, L, 8'd1);
        v("and",   L, H, L, 5'h00, L, 0,  H, L, L, 8'd1);
        v("and",   L, L, L, 5'h1F, H, 0,  H, L, L, 8'd1);
        v("and",   L, L, H, 5'h00, L, 0,  L, L, L, 8'd0);
        v("and",   L, L, L, 5'h00, L, 0,  L, L, L, 8'd0);
        // qualification: 3-cycle run too short, 4-cycle run triggers
        v("qual",  L, H, L, 5'h00, L, 1,  L, L, H, 8'd0);
        for (int i = 0; i < 3; i++) v("qual", L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        v("qual",  L, H, L, 5'h1B, L, 1,  L, L, H, 8'd0);
        for (int i = 0; i < 3; i++) v("qual", L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        v("qual",  L, H, L, 5'h04, L, 1,  H, H, L, 8'd1);
        v("qual",  L, H, H, 5'h04, L, 1,  L, L, L, 8'd0);
        v("rearm", L, H, L, 5'h00, L, 1,  L, L, H, 8'd0);
        v("rearm", L, L, L, 5'h00, L, 1,  L, L, L, 8'd0);
        // event counting, a long pulse counts once
        v("cnt",   L, H, L, 5'h00, L, 2,  L, L, H, 8'd0);
        v("cnt",   L, H, L, 5'h01, L, 2,  L, L, H, 8'd1);
        v("cnt",   L, H, L, 5'h01, L, 2,  L, L, H, 8'd1);
        v("cnt",   L, H, L, 5'h00, L, 2,  L, L, H, 8'd1);
        for (int i = 0; i < 5; i++) v("cnt", L, H, L, 5'h01, L, 2,  L, L, H, 8'd2);
        v("cnt",   L, H, L, 5'h00, L, 2,  L, L, H, 8'd2);
        v("cnt",   L, H, L, 5'h01, L, 2,  H, H, L, 8'd3);
        v("cnt",   L, H, L, 5'h01, L, 2,  H, L, L, 8'd3);
        v("cnt",   L, L, H, 5'h00, L, 2,  L, L, L, 8'd0);
        // disarm coincident with final event
        v("disarm", L, H, L, 5'h00, L, 0, L, L, H, 8'd0);
        v("disarm", L, L, L, 5'h1F, H, 0, L, L, L, 8'd0);
        v("disarm", L, L, L, 5'h1F, H, 0, L, L, L, 8'd0);
        // disarm clears a partial count
        v("clr",   L, H, L, 5'h00, L, 2,  L, L, H, 8'd0);
        v("clr",   L, H, L, 5'h01, L, 2,  L, L, H, 8'd1);
        v("clr",   L, H, L, 5'h00, L, 2,  L, L, H, 8'd1);
        v("clr",   L, L, L, 5'h01, L, 2,  L, L, L, 8'd0);
        // event_cnt of zero behaves as one
        v("ecnt0", L, H, L, 5'h00, L, 5,  L, L, H, 8'd0);
        v("ecnt0", L, H, L, 5'h01, L, 5,  H, H, L, 8'd1);
        v("ecnt0", L, L, H, 5'h00, L, 5,  L, L, L, 8'd0);
        // protocol trigger as the only term
        v("prot",  L, H, L, 5'h00, L, 6,  L, L, H, 8'd0);
        v("prot",  L, H, L, 5'h1F, L, 6,  L, L, H, 8'd0);
        v("prot",  L, H, L, 5'h00, H, 6,  H, H, L, 8'd1);
        v("prot",  L, L, H, 5'h00, L, 6,  L, L, L, 8'd0);
        // reset mid-qualification, then a fresh full qualification
        v("rstq",  L, H, L, 5'h00, L, 1,  L, L, H, 8'd0);
        v("rstq",  L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        v("rstq",  L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        v("rstq",  H, H, L, 5'h04, L, 1,  L, L, L, 8'd0);
        v("rstq",  L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        for (int i = 0; i < 3; i++) v("rstq", L, H, L, 5'h04, L, 1,  L, L, H, 8'd0);
        v("rstq",  L, H, L, 5'h04, L, 1,  H, H, L, 8'd1);
        // reset in TRIG, re-arm, live config changes ignored while armed
        v("rstt",  H, H, L, 5'h00, L, 1,  L, L, L, 8'd0);
        v("rstt",  L, H, L, 5'h00, L, 1,  L, L, H, 8'd0);
        for (int i = 0; i < 3; i++) v("rstt", L, H, L, 5'h1F, H, 0,  L, L, H, 8'd0);
        v("rstt",  L, H, L, 5'h1F, H, 0,  H, H, L, 8'd1);
        v("rstt",  L, L, H, 5'h00, L, 2,  L, L, L, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i], $sformatf("%s#%0d", vecs[i].tag, i));
        end

        // zero participating terms never match, in AND and in OR mode
        for (int m = 3; m <= 4; m++) begin
            x = '{"zero", L, H, L, 5'h00, L, m, L, L, H, 8'd0};
            drive_cycle(x, $sformatf("zero_arm_cfg%0d", m));
            x = '{"zero", L, H, L, 5'h1F, H, m, L, L, H, 8'd0};
            for (int c = 0; c < 100; c++) begin
                drive_cycle(x, $sformatf("zero_cfg%0d_c%0d", m, c));
            end
            x = '{"zero", L, L, L, 5'h00, L, m, L, L, L, 8'd0};
            drive_cycle(x, $sformatf("zero_disarm_cfg%0d", m));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
